sequence_detector_fsm_state_register: RTL and testbench

//   State-holding half of the 0000/1111 sequence detector. Registers the 4-bit next-state code

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/sat_counter.sv | 33 +++
 rtl/sequence_detector_fsm_state_register.sv | 71 +++++++
 tb/tb_sequence_detector_fsm_state_register.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the 0000/1111 sequence detector: state width, state codes
// and the Moore-output decode used by both the next-state logic and the state register.
package seq_det_pkg;
    localparam int STATE_W = 4;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t A = 4'd0;
    localparam state_t B = 4'd1;
    localparam state_t C = 4'd2;
    localparam state_t D = 4'd3;
    localparam state_t E = 4'd4;
    localparam state_t F = 4'd5;
    localparam state_t G = 4'd6;
    localparam state_t H = 4'd7;
    localparam state_t I = 4'd8;

    localparam state_t LAST_LEGAL = I;

    // E means four zeros were seen, I means four ones were seen.
    function automatic logic is_match(input state_t s);
        return (s == E) || (s == I);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear on the same edge as an
// increment wins and leaves the counter at zero.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q = count_q;
endmodule

// File: rtl/sequence_detector_fsm_state_register.sv
// State register of the 0000/1111 detector: loads the next-state code, decodes the
// Moore output, pulses on each new match, counts matches and flags illegal codes.
module sequence_detector_fsm_state_register
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               en,
    input  logic [3:0]         nextstate,
    input  logic               clr_count,
    output logic [3:0]         currstate,
    output logic               z,
    output logic               z_rise,
    output logic [CNT_W-1:0]   match_count,
    output logic               illegal
);
    state_t state_q, state_d;
    logic   z_q, z_d;
    logic   z_rise_q, z_rise_d;
    logic   illegal_q, illegal_d;

    always_comb begin
        state_d   = state_q;
        z_d       = z_q;
        z_rise_d  = 1'b0;
        illegal_d = illegal_q;
        if (en) begin
            // Out-of-range codes fall back to the reset state so the detector restarts cleanly.
            if (nextstate <= LAST_LEGAL) begin
                state_d = nextstate;
            end else begin
                state_d   = A;
                illegal_d = 1'b1;
            end
            z_d      = is_match(state_d);
            z_rise_d = z_d && !z_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= A;
            z_q       <= 1'b0;
            z_rise_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            z_q       <= z_d;
            z_rise_q  <= z_rise_d;
            illegal_q <= illegal_d;
        end
    end

    // The counter steps on the same edge that registers the rising pulse.
    sat_counter #(
        .W(CNT_W)
    ) u_match_counter (
        .Clock (Clock),
        .Resetn(Resetn),
        .inc   (z_rise_d),
        .clr   (clr_count),
        .q     (match_count)
    );

    assign currstate = state_q;
    assign z         = z_q;
    assign z_rise    = z_rise_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_sequence_detector_fsm_state_register.sv
// Bench: behavioural next-state logic driving two state-register instances (CNT_W=8 and 2),
// checked against hand-computed vectors and a saturation/clear sequence.
module tb_sequence_detector_fsm_state_register;
    logic       clk = 1'b0;
    logic       Resetn, en, w, clr_count, force_ill;
    logic [3:0] ns1, ns2, cs1, cs2;
    logic       z1, z2, zr1, zr2, ill1, ill2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] nxt(input logic [3:0] s, input logic win);
        case (s)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: nxt = win ? 4'd5 : ((s == 4'd4) ? 4'd4 : s + 4'd1);
            4'd5, 4'd6, 4'd7, 4'd8:       nxt = win ? ((s == 4'd8) ? 4'd8 : s + 4'd1) : 4'd1;
            default:                      nxt = 4'd0;
        endcase
    endfunction

    always_comb begin
        ns1 = force_ill ? 4'hF : nxt(cs1, w);
        ns2 = force_ill ? 4'hF : nxt(cs2, w);
    end

    sequence_detector_fsm_state_register #(.CNT_W(8)) dut1 (
        .Clock(clk), .Resetn(Resetn), .en(en), .nextstate(ns1), .clr_count(clr_count),
        .currstate(cs1), .z(z1), .z_rise(zr1), .match_count(cnt1), .illegal(ill1)
    );

    sequence_detector_fsm_state_register #(.CNT_W(2)) dut2 (
        .Clock(clk), .Resetn(Resetn), .en(en), .nextstate(ns2), .clr_count(clr_count),
        .currstate(cs2), .z(z2), .z_rise(zr2), .match_count(cnt2), .illegal(ill2)
    );

    typedef struct {
        bit rstn; bit en; bit w; bit clr; bit fill;
        int cs; bit z; bit rise; int cnt; bit ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rstn, input bit e, input bit wi, input bit c, input bit fi,
                       input int cs, input bit zz, input bit r, input int cn, input bit il);
        vec_t v;
        v.rstn = rstn; v.en = e; v.w = wi; v.clr = c; v.fill = fi;
        v.cs = cs; v.z = zz; v.rise = r; v.cnt = cn; v.ill = il;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit rstn, input bit e, input bit wi, input bit c, input bit fi);
        @(negedge clk);
        Resetn = rstn; en = e; w = wi; clr_count = c; force_ill = fi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp2[6];
        Resetn = 1'b0; en = 1'b0; w = 1'b0; clr_count = 1'b0; force_ill = 1'b0;

        //   rstn en w clr fill   cs z r cnt ill
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   2, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   3, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   4, 1, 1, 1, 0);
        add(1, 1, 0, 0, 0,   4, 1, 0, 1, 0);
        add(1, 1, 1, 0, 0,   5, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0,   6, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0,   7, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0,   8, 1, 1, 2, 0);
        add(1, 1, 0, 0, 0,   1, 0, 0, 2, 0);
        add(1, 1, 1, 0, 0,   5, 0, 0, 2, 0);
        add(1, 1, 1, 0, 0,   6, 0, 0, 2, 0);
        add(1, 0, 0, 0, 0,   6, 0, 0, 2, 0);
        add(1, 0, 1, 0, 0,   6, 0, 0, 2, 0);
        add(1, 0, 0, 0, 0,   6, 0, 0, 2, 0);
        add(1, 1, 1, 0, 0,   7, 0, 0, 2, 0);
        add(1, 1, 0, 0, 1,   0, 0, 0, 2, 1);
        add(1, 1, 0, 0, 0,   1, 0, 0, 2, 1);
        add(1, 1, 1, 0, 0,   5, 0, 0, 2, 1);
        add(0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   2, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   2, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   3, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   4, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0,   4, 1, 0, 1, 0);
        add(1, 1, 0, 1, 0,   4, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rstn, vecs[i].en, vecs[i].w, vecs[i].clr, vecs[i].fill);
            check($sformatf("v%0d_cs", i), cs1, vecs[i].cs);
            check($sformatf("v%0d_z", i), z1, vecs[i].z);
            check($sformatf("v%0d_rise", i), zr1, vecs[i].rise);
            check($sformatf("v%0d_cnt", i), cnt1, vecs[i].cnt);
            check($sformatf("v%0d_ill", i), ill1, vecs[i].ill);
            $display("vec %0d: cs=%0d z=%0b rise=%0b cnt=%0d ill=%0b", i, cs1, z1, zr1, cnt1, ill1);
        end

        // Saturation of the 2-bit counter, then clear colliding with a 6th detection.
        exp2[0] = 1; exp2[1] = 2; exp2[2] = 3; exp2[3] = 3; exp2[4] = 3; exp2[5] = 0;
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) drive(1, 1, 1, 0, 0);
            for (int j = 0; j < 3; j++) drive(1, 1, 0, 0, 0);
            drive(1, 1, 0, (k == 5), 0);
            check($sformatf("sat%0d_cnt2", k), cnt2, exp2[k]);
            check($sformatf("sat%0d_rise2", k), zr2, 1);
            check($sformatf("sat%0d_cnt1", k), cnt1, (k == 5) ? 0 : k + 1);
            $display("det %0d: cnt2=%0d cnt1=%0d rise=%0b", k, cnt2, cnt1, zr2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
